// File: rtl/bus_demux_pkg.sv
// Shared bus constants and select encodings for the 4:1 bus demux.
// The source-side mux uses the same select encodings.
package bus_demux_pkg;

  localparam int BUS_WIDTH = 16;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_e;

  function automatic logic [3:0] sel_onehot(input logic [1:0] s);
    logic [3:0] v;
    v = 4'b0000;
    case (s)
      SEL_A:   v = 4'b0001;
      SEL_B:   v = 4'b0010;
      SEL_C:   v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bus_demux_slot.sv
// One-entry holding register with valid/ready handshake toward a sink.
// Flush wins over load, load wins over drain.
module bus_demux_slot
  import bus_demux_pkg::*;
#(
  parameter int W = BUS_WIDTH
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_demux.sv
// Destination side of the 4:1 datapath bus: routes one word per
// cycle into one of four independently handshaked sink slots.
module bus_demux
  import bus_demux_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [1:0]       Select,
  input  logic [WIDTH-1:0] BusIn,
  input  logic             BusValid,
  output logic             BusReady,
  input  logic             Flush,
  output logic [WIDTH-1:0] OutputA,
  output logic [WIDTH-1:0] OutputB,
  output logic [WIDTH-1:0] OutputC,
  output logic [WIDTH-1:0] OutputD,
  output logic             ValidA,
  output logic             ValidB,
  output logic             ValidC,
  output logic             ValidD,
  input  logic             ReadyA,
  input  logic             ReadyB,
  input  logic             ReadyC,
  input  logic             ReadyD,
  output logic             Busy
);

  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] load;
  logic [3:0] valid_nxt;
  logic       accept;

  assign ready = {ReadyD, ReadyC, ReadyB, ReadyA};
  assign valid = {ValidD, ValidC, ValidB, ValidA};

  // Never depends on BusValid, so the source may wait on it.
  assign BusReady = !Flush && (!valid[Select] || ready[Select]);
  assign accept   = BusValid && BusReady;
  assign load     = sel_onehot(Select) & {4{accept}};

  assign valid_nxt = Flush ? 4'b0000
                   : (load | (valid & ~ready));

  bus_demux_slot #(.W(WIDTH)) u_slot_a (
    .Clk(Clk), .Rst_n(Rst_n), .flush(Flush),
    .load(load[0]), .data(BusIn), .ready(ReadyA),
    .q(OutputA), .valid(ValidA)
  );

  bus_demux_slot #(.W(WIDTH)) u_slot_b (
    .Clk(Clk), .Rst_n(Rst_n), .flush(Flush),
    .load(load[1]), .data(BusIn), .ready(ReadyB),
    .q(OutputB), .valid(ValidB)
  );

  bus_demux_slot #(.W(WIDTH)) u_slot_c (
    .Clk(Clk), .Rst_n(Rst_n), .flush(Flush),
    .load(load[2]), .data(BusIn), .ready(ReadyC),
    .q(OutputC), .valid(ValidC)
  );

  bus_demux_slot #(.W(WIDTH)) u_slot_d (
    .Clk(Clk), .Rst_n(Rst_n), .flush(Flush),
    .load(load[3]), .data(BusIn), .ready(ReadyD),
    .q(OutputD), .valid(ValidD)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Busy <= 1'b0;
    else        Busy <= |valid_nxt;
  end

endmodule

// File: tb/tb_bus_demux.sv
// Directed-vector bench for bus_demux.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_bus_demux;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [1:0]  Select;
  logic [15:0] BusIn;
  logic        BusValid;
  logic        BusReady;
  logic        Flush;
  logic [15:0] OutputA, OutputB, OutputC, OutputD;
  logic        ValidA, ValidB, ValidC, ValidD;
  logic        ReadyA, ReadyB, ReadyC, ReadyD;
  logic        Busy;

  int vecs = 0;
  int errs = 0;
  int hs_a = 0;
  int hs_base;

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (ValidA && ReadyA) hs_a++;

  bus_demux dut (
    .Clk(Clk), .Rst_n(Rst_n), .Select(Select), .BusIn(BusIn),
    .BusValid(BusValid), .BusReady(BusReady), .Flush(Flush),
    .OutputA(OutputA), .OutputB(OutputB),
    .OutputC(OutputC), .OutputD(OutputD),
    .ValidA(ValidA), .ValidB(ValidB), .ValidC(ValidC), .ValidD(ValidD),
    .ReadyA(ReadyA), .ReadyB(ReadyB), .ReadyC(ReadyC), .ReadyD(ReadyD),
    .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [15:0] d);
    Select   = s;
    BusIn    = d;
    BusValid = 1'b1;
    tick();
    BusValid = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; Select = 2'd0; BusIn = '0; BusValid = 1'b0;
    Flush = 1'b0;
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0; ReadyD = 1'b0;
    #12;
    chk("rst_valid", {12'h0, ValidD, ValidC, ValidB, ValidA}, 16'h0);
    chk("rst_outa", OutputA, 16'h0000);
    chk("rst_outd", OutputD, 16'h0000);
    chk("rst_busy", {15'h0, Busy}, 16'h0);
    tick();
    Rst_n = 1'b1;
    tick();

    // single delivery to C
    Select = 2'd2; BusIn = 16'hBEEF; BusValid = 1'b1;
    #1 chk("single_ready", {15'h0, BusReady}, 16'h1);
    tick();
    BusValid = 1'b0;
    chk("single_validc", {15'h0, ValidC}, 16'h1);
    chk("single_outc", OutputC, 16'hBEEF);
    chk("single_busy", {15'h0, Busy}, 16'h1);
    chk("single_others", {13'h0, ValidD, ValidB, ValidA}, 16'h0);
    ReadyC = 1'b1;
    tick();
    ReadyC = 1'b0;
    chk("drain_validc", {15'h0, ValidC}, 16'h0);
    chk("drain_outc", OutputC, 16'hBEEF);
    chk("drain_busy", {15'h0, Busy}, 16'h0);

    // backpressure on B
    send(2'd1, 16'h1111);
    Select = 2'd1; BusIn = 16'h2222; BusValid = 1'b1;
    #1 chk("bp_ready0", {15'h0, BusReady}, 16'h0);
    tick();
    chk("bp_outb_held", OutputB, 16'h1111);
    chk("bp_validb", {15'h0, ValidB}, 16'h1);
    ReadyB = 1'b1;
    #1 chk("bp_ready1", {15'h0, BusReady}, 16'h1);
    tick();
    BusValid = 1'b0; ReadyB = 1'b0;
    chk("bp_outb_new", OutputB, 16'h2222);
    chk("bp_validb2", {15'h0, ValidB}, 16'h1);
    ReadyB = 1'b1;
    tick();
    ReadyB = 1'b0;

    // simultaneous drain and load on A
    send(2'd0, 16'hAAAA);
    hs_base = hs_a;
    ReadyA = 1'b1;
    Select = 2'd0; BusIn = 16'h5555; BusValid = 1'b1;
    #1 chk("sim_ready", {15'h0, BusReady}, 16'h1);
    tick();
    ReadyA = 1'b0; BusValid = 1'b0;
    chk("sim_valida", {15'h0, ValidA}, 16'h1);
    chk("sim_outa", OutputA, 16'h5555);
    chk("sim_hs", 16'(hs_a - hs_base), 16'd1);
    ReadyA = 1'b1;
    tick();
    ReadyA = 1'b0;

    // D stalled, A..C back-to-back
    send(2'd3, 16'hDDDD);
    BusValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Select = 2'(i);
      BusIn  = 16'h1001 * 16'(i + 1);
      #1 chk($sformatf("indep_ready%0d", i), {15'h0, BusReady}, 16'h1);
      tick();
    end
    BusValid = 1'b0;
    chk("indep_outa", OutputA, 16'h1001);
    chk("indep_outb", OutputB, 16'h2002);
    chk("indep_outc", OutputC, 16'h3003);
    chk("indep_valid", {12'h0, ValidD, ValidC, ValidB, ValidA}, 16'hF);
    chk("indep_outd", OutputD, 16'hDDDD);

    // flush with a pending word
    Flush = 1'b1; Select = 2'd0; BusIn = 16'hF00D; BusValid = 1'b1;
    #1 chk("flush_ready", {15'h0, BusReady}, 16'h0);
    tick();
    Flush = 1'b0; BusValid = 1'b0;
    chk("flush_valid", {12'h0, ValidD, ValidC, ValidB, ValidA}, 16'h0);
    chk("flush_busy", {15'h0, Busy}, 16'h0);
    chk("flush_outa", OutputA, 16'h1001);

    // mid-operation async reset
    send(2'd0, 16'h7777);
    send(2'd3, 16'h8888);
    chk("pre_rst_busy", {15'h0, Busy}, 16'h1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_valid", {12'h0, ValidD, ValidC, ValidB, ValidA}, 16'h0);
    chk("arst_outa", OutputA, 16'h0000);
    chk("arst_outd", OutputD, 16'h0000);
    chk("arst_busy", {15'h0, Busy}, 16'h0);
    tick();
    Rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
